fwvip_wb_target: RTL and testbench

FWVIP_WB_TARGET -- requirements
Module: fwvip_wb_target

---
 rtl/fwvip_wb_pkg.sv | 21 ++
 rtl/fwvip_wb_target_mem.sv | 36 +++
 rtl/fwvip_wb_target.sv | 165 ++++++++++++++++
 tb/tb_fwvip_wb_target.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fwvip_wb_pkg.sv
// Shared types and sizing helpers for the Wishbone target: FSM state encoding,
// byte-lane count and byte-offset width derived from the data width.
package fwvip_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam int COUNT_WIDTH = 4;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int offset_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/fwvip_wb_target_mem.sv
// Word storage for the Wishbone target: one synchronous byte-enable write port
// and one asynchronous read port. Contents are never reset.
module fwvip_wb_target_mem
  import fwvip_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                    clock,
  input  logic                    wr_en,
  input  logic [DEPTH_LOG2-1:0]   wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_sel,
  input  logic [DEPTH_LOG2-1:0]   rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);
  localparam int LANES = lane_count(DATA_WIDTH);
  localparam int WORDS = 2 ** DEPTH_LOG2;

  // One byte-wide array per lane keeps each lane's write enable independent.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];

      always_ff @(posedge clock) begin
        if (wr_en && wr_sel[gi]) begin
          lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
        end
      end

      assign rd_data[gi*8 +: 8] = lane_mem[rd_idx];
    end
  endgenerate

endmodule

// File: rtl/fwvip_wb_target.sv
// Wishbone B4 classic responder with byte-lane storage and WAIT_CYCLES wait states.
// Define FWVIP_WB_TARGET_ERR_EN to answer out-of-range accesses with err instead of ack.
module fwvip_wb_target
  import fwvip_wb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   adr,
  input  logic [DATA_WIDTH-1:0]   dat_w,
  output logic [DATA_WIDTH-1:0]   dat_r,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] sel,
  output logic                    ack,
  output logic                    err
);
  localparam int LANES = lane_count(DATA_WIDTH);
  localparam int OFFS  = offset_width(DATA_WIDTH);

  wb_state_e               state_reg;
  logic [COUNT_WIDTH-1:0]  cnt_reg;
  logic [ADDR_WIDTH-1:0]   adr_reg;
  logic [DATA_WIDTH-1:0]   dat_w_reg;
  logic                    we_reg;
  logic [LANES-1:0]        sel_reg;
  logic                    ack_reg;
  logic                    err_reg;
  logic [DATA_WIDTH-1:0]   dat_r_reg;

  logic [ADDR_WIDTH-1:0]   cur_adr;
  logic [DATA_WIDTH-1:0]   cur_dat;
  logic                    cur_we;
  logic [LANES-1:0]        cur_sel;
  logic [ADDR_WIDTH-1:0]   word_adr;
  logic [DEPTH_LOG2-1:0]   word_idx;
  logic                    out_of_range;
  logic                    accept;
  logic                    enter_resp;
  logic                    mem_wr_en;
  logic [DATA_WIDTH-1:0]   mem_rd_data;
  logic                    resp_ack;
  logic                    resp_err;
  logic [DATA_WIDTH-1:0]   resp_dat;

  // With no wait states the response is formed on the accepting edge, so the
  // live bus inputs are used there; otherwise the captured request is used.
  always_comb begin
    cur_adr = adr_reg;
    cur_dat = dat_w_reg;
    cur_we  = we_reg;
    cur_sel = sel_reg;
    if (state_reg == IDLE) begin
      cur_adr = adr;
      cur_dat = dat_w;
      cur_we  = we;
      cur_sel = sel;
    end
  end

  assign word_adr     = cur_adr >> OFFS;
  assign word_idx     = word_adr[DEPTH_LOG2-1:0];
  assign out_of_range = |(word_adr >> DEPTH_LOG2);

  assign accept     = (state_reg == IDLE) && cyc && stb && !ack_reg && !err_reg;
  assign enter_resp = (WAIT_CYCLES == 0) ? accept
                    : ((state_reg == WAIT) && cyc && (cnt_reg == 4'd1));
  assign mem_wr_en  = enter_resp && cur_we && !out_of_range;

  always_comb begin
`ifdef FWVIP_WB_TARGET_ERR_EN
    resp_ack = !out_of_range;
    resp_err = out_of_range;
`else
    resp_ack = 1'b1;
    resp_err = 1'b0;
`endif
    resp_dat = '0;
    if (!cur_we && !out_of_range) begin
      resp_dat = mem_rd_data;
    end
  end

  fwvip_wb_target_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clock   (clock),
    .wr_en   (mem_wr_en),
    .wr_idx  (word_idx),
    .wr_data (cur_dat),
    .wr_sel  (cur_sel),
    .rd_idx  (word_idx),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      adr_reg   <= '0;
      dat_w_reg <= '0;
      we_reg    <= 1'b0;
      sel_reg   <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      dat_r_reg <= '0;
    end else begin
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      dat_r_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            adr_reg   <= adr;
            dat_w_reg <= dat_w;
            we_reg    <= we;
            sel_reg   <= sel;
            if (WAIT_CYCLES > 0) begin
              state_reg <= WAIT;
              cnt_reg   <= COUNT_WIDTH'(WAIT_CYCLES);
            end else begin
              state_reg <= RESP;
              ack_reg   <= resp_ack;
              err_reg   <= resp_err;
              dat_r_reg <= resp_dat;
            end
          end
        end
        WAIT: begin
          // Master withdrawing cyc abandons the transfer with no response.
          if (!cyc) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == 4'd1) begin
            state_reg <= RESP;
            cnt_reg   <= '0;
            ack_reg   <= resp_ack;
            err_reg   <= resp_err;
            dat_r_reg <= resp_dat;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign ack   = ack_reg;
  assign err   = err_reg;
  assign dat_r = dat_r_reg;

endmodule

// File: tb/tb_fwvip_wb_target.sv
// Randomized bench for fwvip_wb_target: one instance without wait states and one
// with three, both checked against a byte-lane memory model kept in the bench.
module tb_fwvip_wb_target;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DL = 8;
  localparam int NW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] adr   = '0;
  logic [DW-1:0] dat_w = '0;
  logic          we    = 1'b0;
  logic [3:0]    sel   = '0;
  logic          cyc_v   [2];
  logic          stb_v   [2];
  logic          ack_v   [2];
  logic          err_v   [2];
  logic [DW-1:0] dat_r_v [2];

  logic [31:0] model [2][256];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  fwvip_wb_target #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .WAIT_CYCLES(0)) u_dut0 (
    .clock(clock), .reset(reset), .adr(adr), .dat_w(dat_w), .dat_r(dat_r_v[0]),
    .cyc(cyc_v[0]), .stb(stb_v[0]), .we(we), .sel(sel), .ack(ack_v[0]), .err(err_v[0])
  );

  fwvip_wb_target #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .WAIT_CYCLES(3)) u_dut3 (
    .clock(clock), .reset(reset), .adr(adr), .dat_w(dat_w), .dat_r(dat_r_v[1]),
    .cyc(cyc_v[1]), .stb(stb_v[1]), .we(we), .sel(sel), .ack(ack_v[1]), .err(err_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // Full transfer on instance d; call at a falling edge, returns at a falling edge.
  task automatic do_xfer(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] s);
    int          lat;
    logic        got_ack, got_err, inr, exp_ack, exp_err;
    logic [31:0] got_rd, exp_rd;
    int          exp_lat;
    inr     = (a < 32'd1024);
    exp_rd  = (!w && inr) ? model[d][a / 4] : 32'h0;
    exp_lat = (d == 0) ? 1 : 4;
`ifdef FWVIP_WB_TARGET_ERR_EN
    exp_err = !inr;
`else
    exp_err = 1'b0;
`endif
    exp_ack = !exp_err;
    adr = a; dat_w = wd; we = w; sel = s;
    cyc_v[d] = 1'b1; stb_v[d] = 1'b1;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; got_rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (ack_v[d] || err_v[d]) begin
        lat = i; got_ack = ack_v[d]; got_err = err_v[d]; got_rd = dat_r_v[d];
        break;
      end
      // Request already captured; these must not influence the transfer.
      adr = $urandom; dat_w = $urandom; we = 1'($urandom); sel = 4'($urandom);
    end
    cyc_v[d] = 1'b0; stb_v[d] = 1'b0;
    chk($sformatf("d%0d latency", d), 32'(lat), 32'(exp_lat));
    chk($sformatf("d%0d ack", d), 32'(got_ack), 32'(exp_ack));
    chk($sformatf("d%0d err", d), 32'(got_err), 32'(exp_err));
    chk($sformatf("d%0d dat_r", d), got_rd, exp_rd);
    if (w && inr) model[d][a / 4] = merge(model[d][a / 4], wd, s);
    @(negedge clock);
    chk($sformatf("d%0d pulse_width", d), {30'h0, ack_v[d], err_v[d]}, 32'h0);
    chk($sformatf("d%0d dat_r_idle", d), dat_r_v[d], 32'h0);
    $display("xfer d=%0d we=%0b adr=%h dat_w=%h sel=%h lat=%0d ack=%0b err=%0b dat_r=%h",
             d, w, a, wd, s, lat, got_ack, got_err, got_rd);
  endtask

  // Write on the wait-state instance, withdrawn while still waiting.
  task automatic do_abort(input logic [31:0] a, input logic [31:0] wd);
    logic seen;
    seen = 1'b0;
    adr = a; dat_w = wd; we = 1'b1; sel = 4'hF;
    cyc_v[1] = 1'b1; stb_v[1] = 1'b1;
    @(negedge clock);
    @(negedge clock);
    cyc_v[1] = 1'b0; stb_v[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (ack_v[1] || err_v[1]) seen = 1'b1;
    end
    chk("abort_no_response", 32'(seen), 32'h0);
    $display("abort d=1 adr=%h dat_w=%h response_seen=%0b", a, wd, seen);
  endtask

  // Reset pulled while the wait-state instance is mid-write.
  task automatic do_reset_in_wait(input logic [31:0] a, input logic [31:0] wd);
    logic seen;
    seen = 1'b0;
    adr = a; dat_w = wd; we = 1'b1; sel = 4'hF;
    cyc_v[1] = 1'b1; stb_v[1] = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_wait ack", 32'(ack_v[1]), 32'h0);
    chk("rst_wait err", 32'(err_v[1]), 32'h0);
    chk("rst_wait dat_r", dat_r_v[1], 32'h0);
    @(negedge clock);
    cyc_v[1] = 1'b0; stb_v[1] = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (ack_v[1] || err_v[1]) seen = 1'b1;
    end
    chk("rst_wait no_response", 32'(seen), 32'h0);
    $display("reset_in_wait d=1 adr=%h dat_w=%h response_seen=%0b", a, wd, seen);
  endtask

  // Reset pulled while instance 0 holds ack high: outputs must drop without a clock edge.
  task automatic do_reset_in_resp(input logic [31:0] a);
    adr = a; we = 1'b0; sel = 4'hF;
    cyc_v[0] = 1'b1; stb_v[0] = 1'b1;
    @(negedge clock);
    chk("rst_resp ack_before", 32'(ack_v[0]), 32'h1);
    chk("rst_resp dat_r_before", dat_r_v[0], model[0][a / 4]);
    reset = 1'b0;
    #1;
    chk("rst_resp ack", 32'(ack_v[0]), 32'h0);
    chk("rst_resp dat_r", dat_r_v[0], 32'h0);
    cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    $display("reset_in_resp d=0 adr=%h", a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int d;
    for (int k = 0; k < 2; k++) begin
      cyc_v[k] = 1'b0; stb_v[k] = 1'b0;
    end
    repeat (2) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d reset ack", k), 32'(ack_v[k]), 32'h0);
      chk($sformatf("d%0d reset err", k), 32'(err_v[k]), 32'h0);
      chk($sformatf("d%0d reset dat_r", k), dat_r_v[k], 32'h0);
    end
    reset = 1'b1;
    @(negedge clock);

    // Give every exercised word a known value.
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < NW; w++) do_xfer(k, 1'b1, 32'(w * 4), $urandom, 4'hF);

    do_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF);
    chk("deadbeef_model", model[0][4], 32'hDEADBEEF);
    do_xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    do_xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h2);
    do_xfer(0, 1'b0, 32'h20, 32'h0, 4'hF);
    chk("lane_merge_model", model[0][8], 32'h1122CC44);
    do_xfer(1, 1'b0, 32'h20, 32'h0, 4'hF);
    do_xfer(0, 1'b1, 32'h30, 32'h55AA55AA, 4'h0);
    do_xfer(0, 1'b0, 32'h31, 32'h0, 4'hF);
    for (int k = 0; k < 2; k++) begin
      do_xfer(k, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF);
      do_xfer(k, 1'b0, 32'h000, 32'h0, 4'hF);
      do_xfer(k, 1'b0, 32'h400, 32'h0, 4'hF);
    end
    do_abort(32'h8, 32'h5);
    do_xfer(1, 1'b0, 32'h8, 32'h0, 4'hF);
    do_reset_in_wait(32'hC, 32'hCAFEF00D);
    do_xfer(1, 1'b0, 32'hC, 32'h0, 4'hF);
    do_xfer(1, 1'b1, 32'hC, 32'h12345678, 4'hF);
    do_xfer(1, 1'b0, 32'hC, 32'h0, 4'hF);
    do_reset_in_resp(32'h10);
    do_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF);

    for (int n = 0; n < 80; n++) begin
      d = int'($urandom_range(1, 0));
      if ($urandom_range(9, 0) != 0) a = 32'($urandom_range(NW - 1, 0) * 4 + $urandom_range(3, 0));
      else a = (32'h1 << $urandom_range(31, 10)) | 32'($urandom_range(1023, 0));
      do_xfer(d, 1'($urandom), a, $urandom, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
